// File: rtl/mini_mips_pkg.sv
// Shared mini-MIPS types: opcode classes, jump sub-ops, error codes and the
// structured request consumed by the instruction encoder.
package mini_mips_pkg;

  typedef enum logic [2:0] {
    Str    = 3'd0,
    Ldr    = 3'd1,
    Mov    = 3'd2,
    Shift  = 3'd3,
    Saddto = 3'd4,
    Jump   = 3'd5,
    Xor    = 3'd6,
    And    = 3'd7
  } op_e;

  // Jump sub-op space: 0 is compare, the branch codes run Ble..Bof.
  localparam logic [3:0] JMP_CMP = 4'h0;
  localparam logic [3:0] JMP_BLE = 4'h4;
  localparam logic [3:0] JMP_BOF = 4'hF;
  localparam logic [3:0] JMP_HOLE = 4'h9;

  typedef enum logic [2:0] {
    ErrNone = 3'd0,
    ErrImm  = 3'd1,
    ErrJump = 3'd2,
    ErrAnd  = 3'd3,
    ErrOvf  = 3'd4
  } err_e;

  typedef struct packed {
    op_e        op;
    logic [3:0] sub;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [1:0] rc;
    logic [3:0] imm;
  } instr_req_t;

  function automatic logic jump_sub_legal(input logic [3:0] sub);
    return (sub == JMP_CMP) ||
           ((sub inside {[JMP_BLE:JMP_BOF]}) && (sub != JMP_HOLE));
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus of the encoder.
// slave = encoder view, master = loader/memory view.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_last;
  logic [2:0]        req_op;
  logic [3:0]        req_sub;
  logic [1:0]        req_ra;
  logic [1:0]        req_rb;
  logic [1:0]        req_rc;
  logic [3:0]        req_imm;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [8:0]        wr_data;

  modport slave (
    input  req_valid, req_last, req_op, req_sub, req_ra, req_rb, req_rc, req_imm,
    output req_ready,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready
  );

  modport master (
    output req_valid, req_last, req_op, req_sub, req_ra, req_rb, req_rc, req_imm,
    input  req_ready,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/instr_field_pack.sv
// Combinational packer: structured request -> 9-bit machine word plus the
// range-check verdict. The opcode always occupies bits [8:6].
module instr_field_pack
  import mini_mips_pkg::*;
(
  input  instr_req_t req,
  output logic [8:0] word,
  output err_e       err
);

  logic [5:0] body;
  logic [3:0] shl_field;

  // Left shifts are stored as a 4-bit negative amount: (16 - imm) mod 16.
  assign shl_field = 4'd0 - req.imm;

  always_comb begin
    body = '0;
    err  = ErrNone;
    case (req.op)
      Str: begin
        body = {req.rb, req.ra, req.imm[1:0]};
        if (req.imm > 4'd3) err = ErrImm;
      end
      Ldr: begin
        body = {req.rc, req.ra, req.imm[1:0]};
        if (req.imm > 4'd3) err = ErrImm;
      end
      Mov: body = {req.rc, req.imm};
      Shift: begin
        if (req.sub[0]) begin
          body = {req.rc, shl_field};
          if ((req.imm == 4'd0) || (req.imm > 4'd8)) err = ErrImm;
        end else begin
          body = {req.rc, req.imm};
          if (req.imm > 4'd7) err = ErrImm;
        end
      end
      Saddto: body = {req.sub[1:0], req.ra, req.rb};
      Jump: begin
        if (req.sub == JMP_CMP) body = {2'b00, req.ra, req.rb};
        else                    body = {req.sub, req.rb};
        if (!jump_sub_legal(req.sub)) err = ErrJump;
      end
      Xor: body = {req.rc, req.ra, req.rb};
      And: begin
        // Bits [2:1] share ra[0] with the ra field, so rb[1] must agree.
        body = {req.rc, req.ra, req.rb[0], 1'b0};
        if (req.ra[0] != req.rb[1]) err = ErrAnd;
      end
    endcase
  end

  assign word = {req.op, body};

endmodule

// File: rtl/instr_encoder.sv
// Streaming assembler back end: packs requests and writes them to instruction
// memory from base_addr upward. Optional ENCODER_CHECKSUM_EN adds a word XOR.
module instr_encoder
  import mini_mips_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int LAST_ADDR = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  instr_encoder_if.slave    bus,
  output logic              err_valid,
  output logic [2:0]        err_code,
  output logic              done,
  output logic              busy
`ifdef ENCODER_CHECKSUM_EN
  ,
  output logic [8:0]        checksum,
  output logic              checksum_valid
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_e;

  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(LAST_ADDR);

  state_e          state;
  logic [ADDR_W:0] cnt;   // extra MSB records the wrap past LAST_ADDR
  instr_req_t      req;
  logic [8:0]      word;
  err_e            pack_err;
  logic            accept;
  logic            wr_fire;
  logic            overflow;
  logic            finish;

  assign req = '{op:  op_e'(bus.req_op), sub: bus.req_sub, ra: bus.req_ra,
                 rb:  bus.req_rb, rc: bus.req_rc, imm: bus.req_imm};

  instr_field_pack u_pack (
    .req  (req),
    .word (word),
    .err  (pack_err)
  );

  assign bus.req_ready = (state == LOAD) && (!bus.wr_valid || bus.wr_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  assign wr_fire       = bus.wr_valid && bus.wr_ready;
  assign overflow      = cnt > LAST;

  // A request is only accepted while the output register is empty or being
  // emptied, so a rejected last request or an overflow never leaves a word
  // behind and can finish directly.
  assign finish = ((state == DRAIN) && wr_fire) ||
                  ((state == LOAD) && accept &&
                   (((pack_err != ErrNone) && bus.req_last) ||
                    ((pack_err == ErrNone) && overflow)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bus.wr_valid <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      err_valid    <= 1'b0;
      err_code     <= ErrNone;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      err_code  <= ErrNone;
      done      <= finish;
      if (wr_fire) bus.wr_valid <= 1'b0;
      if (finish) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            cnt   <= {1'b0, base_addr};
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            if (pack_err != ErrNone) begin
              err_valid <= 1'b1;
              err_code  <= pack_err;
            end else if (overflow) begin
              err_valid <= 1'b1;
              err_code  <= ErrOvf;
            end else begin
              bus.wr_valid <= 1'b1;
              bus.wr_data  <= word;
              bus.wr_addr  <= cnt[ADDR_W-1:0];
              cnt          <= cnt + 1'b1;
              if (bus.req_last) state <= DRAIN;
            end
          end
        end
        DRAIN: ;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ENCODER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum       <= '0;
      checksum_valid <= 1'b0;
    end else begin
      checksum_valid <= finish;
      if ((state == IDLE) && start) checksum <= '0;
      else if (wr_fire)             checksum <= checksum ^ bus.wr_data;
    end
  end
`endif

endmodule
